// File: rtl/jtdd_arb_pkg.sv
// Shared constants and state encoding for the SDRAM slot arbiter.
package jtdd_arb_pkg;
  localparam int ARB_AW = 22;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/jtdd_rr_pick.sv
// Round-robin priority encoder: first pending slot after last_grant, wrapping.
module jtdd_rr_pick #(
  parameter int NSLOT = 4,
  parameter int LW    = (NSLOT > 1) ? $clog2(NSLOT) : 1
)(
  input  logic [NSLOT-1:0] pending,
  input  logic [LW-1:0]    last_grant,
  output logic [LW-1:0]    gnt,
  output logic             any
);
  // Scan from farthest to nearest so the nearest pending slot wins.
  always_comb begin
    int idx;
    idx = 0;
    gnt = last_grant;
    for (int k = NSLOT; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NSLOT;
      if (pending[LW'(idx)]) gnt = LW'(idx);
    end
  end

  assign any = |pending;
endmodule

// File: rtl/jtdd_sdram_arb.sv
// Shares one SDRAM read port among NSLOT ROM slots, each with a one-word cache.
module jtdd_sdram_arb
  import jtdd_arb_pkg::*;
#(
  parameter int NSLOT = 4,
  parameter int AW    = ARB_AW,
  parameter int DW    = ARB_DW
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [NSLOT-1:0]    slot_cs,
  input  logic [NSLOT*AW-1:0] slot_addr,
  output logic [NSLOT*DW-1:0] slot_dout,
  output logic [NSLOT-1:0]    slot_ok,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en
);
  localparam int LW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  arb_state_t state, state_nxt;
  logic [LW-1:0]              gnt_r, last_grant, pick;
  logic [AW-1:0]              addr_l;
  logic [NSLOT-1:0]           hit, pending;
  logic [NSLOT-1:0][AW-1:0]   addr_a;
  logic                       any, grant, fill, req_clr;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    logic          v;
    logic [AW-1:0] tag;
    logic [DW-1:0] data;

    assign addr_a[i] = slot_addr[i*AW +: AW];

    // Fill tags with the latched address, so a slot that moved on stays a miss.
    always_ff @(posedge clk) begin
      if (rst) begin
        v    <= 1'b0;
        tag  <= '0;
        data <= '0;
      end else if (downloading) begin
        v <= 1'b0;
      end else if (fill && gnt_r == LW'(i)) begin
        v    <= 1'b1;
        tag  <= addr_l;
        data <= data_read;
      end
    end

    assign hit[i]                = v && (tag == addr_a[i]);
    assign slot_dout[i*DW +: DW] = data;
  end

  assign pending    = slot_cs & ~hit;
  assign slot_ok    = slot_cs & hit;
  assign refresh_en = (state == ST_IDLE) && !any;

  jtdd_rr_pick #(.NSLOT(NSLOT), .LW(LW)) u_pick (
    .pending   (pending),
    .last_grant(last_grant),
    .gnt       (pick),
    .any       (any)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fill      = 1'b0;
    req_clr   = 1'b0;
    case (state)
      ST_IDLE: if (!downloading && any) begin
        grant     = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: if (downloading) begin
        req_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end else if (sdram_ack) begin
        req_clr   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (downloading) begin
        state_nxt = ST_IDLE;
      end else if (data_rdy) begin
        fill      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt_r      <= '0;
      addr_l     <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      last_grant <= LW'(NSLOT-1);
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_r      <= pick;
        addr_l     <= addr_a[pick];
        sdram_req  <= 1'b1;
        sdram_addr <= addr_a[pick];
        last_grant <= pick;
      end else if (req_clr) begin
        sdram_req <= 1'b0;
      end
    end
  end
endmodule
